light_hash: RTL and testbench
=============================

# light_hash

Byte-serial 64-bit lightweight hash engine built around the AES S-box. A host frames each message with a head command, then one message command per byte, then a tail command. The block absorbs each byte into an 8-byte chaining state through 32 S-box rounds. On tail it publishes a 64-bit digest. It sits behind a simple valid/command bus and is driven directly by a controller or testbench.

## Interface
Parameters: none.

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous reset, active-high (1 = reset), despite the codebase's `_n` name.
- message_byte  in  8  message byte, sampled with a message command.
- message_valid  in  1  a command is sampled on every rising edge where this is 1.
- state  in  2  command code: 00 head, 01 tail, 10 message, 11 none/ignored.
- digest  out  64  final hash, H[0] in [63:56] … H[7] in [7:0].
- digest_ready  out  1  digest valid.
- next_byte  out  1  busy flag; 1 while a byte is being absorbed.

## Operation
- Chaining state H[0..7] (bytes). IV = 34 55 0F 14 DA C0 2B 3E (H[0] first).
- Byte counter LEN: 64 bits, wraps modulo 2^64.
- S(x) is the standard AES forward S-box. Example values: S(00)=63, S(01)=7C, S(53)=ED.
- One round with byte M updates all j = 0..7 simultaneously from the old values:
  - H'[j] = S(H[(j+2) mod 8] XOR M) XOR rotl1(H[j])
  - rotl1 is an 8-bit rotate left by 1.
- Absorbing a byte applies 32 consecutive rounds with the same M, then increments LEN.
- Finalization: digest = {H[0..7]} XOR LEN.
- FSM states:
  - IDLE (after reset): only head is accepted.
  - ACCUM: head, message and tail are accepted.
  - BUSY: round counter 0..31; all commands are ignored.
  - DONE: only head is accepted.
- Head (valid, 00), in IDLE/ACCUM/DONE:
  - H ← IV, LEN ← 0.
  - digest ← 0, digest_ready ← 0.
  - Go to ACCUM.
- Message (valid, 10), in ACCUM:
  - Latch message_byte, next_byte ← 1, round counter ← 0, go to BUSY.
  - After the 32nd round: LEN++, next_byte ← 0, back to ACCUM.
- Tail (valid, 01), in ACCUM:
  - digest ← H XOR LEN, digest_ready ← 1, go to DONE.
  - digest and digest_ready hold until the next head or reset.
- Any command not listed for the current state is ignored with no side effect. This includes code 11 and message/tail in IDLE or DONE.
- Implementation: 8 parallel S-box lookups per cycle (one round per clock).

## Timing
- Reset (async assert, released synchronously by design convention) forces:
  - FSM = IDLE, H = IV, LEN = 0.
  - digest = 0, digest_ready = 0, next_byte = 0.
  - Reset mid-BUSY aborts the byte.
- Commands are single-cycle: one command per edge with message_valid = 1. Holding valid high for several cycles repeats the command on each edge. This is harmless for head/tail, but repeated message commands are ignored while BUSY.
- Message: next_byte rises on the sampling edge E. Rounds execute on edges E+1 … E+32. next_byte falls on edge E+32. The next message may be sampled on edge E+33 or later.
- Tail: digest and digest_ready are registered on the sampling edge, giving 1-cycle latency.
- Head: takes effect on its sampling edge; a message may be sampled on the following edge.

## Test plan
- Reset:
  - Assert rst_n = 1 for 2 cycles → digest = 0, digest_ready = 0, next_byte = 0.
  - Tail while in IDLE → still 0/0.
- Empty message: head, then tail → digest = 34550F14DAC02B3E, digest_ready = 1 one edge after tail.
- Single byte:
  - Head, message 0x61 → next_byte high for exactly 32 cycles.
  - Tail → digest equals the software model's value for "a" (LEN = 1 folded into bit 0).
- Busy rejection:
  - Message 0x41 → while next_byte = 1, issue message 0x42, tail and head.
  - Required: all ignored; final digest equals that for "A" alone.
- Multi-string regression:
  - Hash "H4rdw4r3_Tr0j4n", "AlessandroAndGiacomo", "3.141592653589793238" and a 300+ byte text, back-to-back with head between each.
  - Each digest must match the C reference model.
  - digest_ready clears on each head.
- Async reset mid-BUSY:
  - Assert rst_n during round 10 → outputs go to reset values immediately.
  - Head + "abc" + tail afterwards matches a clean run.

Source files
------------

// File: rtl/light_hash.sv
// Byte-serial 64-bit hash: each message byte is absorbed into an 8-byte chaining
// state through 32 AES S-box rounds (one round per clock); the tail command publishes H ^ LEN.
module light_hash (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  message_byte,
    input  logic        message_valid,
    input  logic [1:0]  state,
    output logic [63:0] digest,
    output logic        digest_ready,
    output logic        next_byte
);

    typedef enum logic [1:0] {IDLE, ACCUM, BUSY, DONE} fsm_t;

    localparam logic [1:0] CMD_HEAD = 2'b00;
    localparam logic [1:0] CMD_TAIL = 2'b01;
    localparam logic [1:0] CMD_MSG  = 2'b10;

    localparam logic [7:0] IV_B [8] = '{8'h34, 8'h55, 8'h0F, 8'h14, 8'hDA, 8'hC0, 8'h2B, 8'h3E};

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    fsm_t        fsm_q, fsm_d;
    logic [7:0]  h_q   [8];
    logic [7:0]  h_rnd [8];
    logic [63:0] len_q;
    logic [7:0]  m_q;
    logic [4:0]  rcnt_q;
    logic        do_head, do_msg, do_tail, do_round, last_round;
    logic        is_head, is_msg, is_tail;
    logic [63:0] h_flat;

    assign is_head = message_valid && (state == CMD_HEAD);
    assign is_msg  = message_valid && (state == CMD_MSG);
    assign is_tail = message_valid && (state == CMD_TAIL);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) fsm_q <= IDLE;
        else       fsm_q <= fsm_d;
    end

    // Command decode: only head/message/tail legal in the current state produce a strobe.
    always_comb begin
        fsm_d      = fsm_q;
        do_head    = 1'b0;
        do_msg     = 1'b0;
        do_tail    = 1'b0;
        do_round   = 1'b0;
        last_round = 1'b0;
        case (fsm_q)
            IDLE, DONE: begin
                if (is_head) begin
                    do_head = 1'b1;
                    fsm_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (is_head) begin
                    do_head = 1'b1;
                end else if (is_msg) begin
                    do_msg = 1'b1;
                    fsm_d  = BUSY;
                end else if (is_tail) begin
                    do_tail = 1'b1;
                    fsm_d   = DONE;
                end
            end
            BUSY: begin
                do_round = 1'b1;
                if (rcnt_q == 5'd31) begin
                    last_round = 1'b1;
                    fsm_d      = ACCUM;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // One full round: all eight bytes updated in parallel from the old state.
    for (genvar j = 0; j < 8; j++) begin : g_rnd
        assign h_rnd[j] = sbox(h_q[(j + 2) % 8] ^ m_q) ^ rotl1(h_q[j]);
    end

    assign h_flat = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            h_q          <= IV_B;
            len_q        <= 64'd0;
            m_q          <= 8'd0;
            rcnt_q       <= 5'd0;
            digest       <= 64'd0;
            digest_ready <= 1'b0;
        end else if (do_head) begin
            h_q          <= IV_B;
            len_q        <= 64'd0;
            digest       <= 64'd0;
            digest_ready <= 1'b0;
        end else if (do_msg) begin
            m_q    <= message_byte;
            rcnt_q <= 5'd0;
        end else if (do_tail) begin
            digest       <= h_flat ^ len_q;
            digest_ready <= 1'b1;
        end else if (do_round) begin
            h_q    <= h_rnd;
            rcnt_q <= rcnt_q + 5'd1;
            if (last_round) len_q <= len_q + 64'd1;
        end
    end

    assign next_byte = (fsm_q == BUSY);

endmodule

// File: tb/tb_light_hash.sv
// Scoreboard bench for light_hash: a reference model built from GF(2^8) arithmetic
// predicts digests, and a monitor checks each digest as digest_ready rises.
module tb_light_hash;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  message_byte = 8'd0;
    logic        message_valid = 1'b0;
    logic [1:0]  state = 2'b11;
    logic [63:0] digest;
    logic        digest_ready;
    logic        next_byte;

    light_hash dut (
        .clk(clk), .rst_n(rst_n), .message_byte(message_byte), .message_valid(message_valid),
        .state(state), .digest(digest), .digest_ready(digest_ready), .next_byte(next_byte)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [63:0] exp_q[$];
    logic [63:0] last_exp;

    // Reference model state
    logic [7:0]  sbox_m [256];
    logic [7:0]  mh [8];
    logic [63:0] mlen;
    int          mode;   // 0 idle, 1 accepting, 2 done

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, v;
        for (int x = 0; x < 256; x++) begin
            v = x[7:0];
            inv = 8'd1;
            repeat (254) inv = gmul(inv, v);
            if (v == 8'd0) inv = 8'd0;
            sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_init();
        logic [63:0] iv;
        iv = 64'h34550F14DAC02B3E;
        for (int j = 0; j < 8; j++) mh[j] = iv[63 - 8*j -: 8];
        mlen = 64'd0;
    endtask

    task automatic model_absorb(input logic [7:0] m);
        logic [7:0] nh [8];
        repeat (32) begin
            for (int j = 0; j < 8; j++) nh[j] = sbox_m[mh[(j + 2) % 8] ^ m] ^ rotl(mh[j], 1);
            mh = nh;
        end
        mlen = mlen + 64'd1;
    endtask

    function automatic logic [63:0] model_digest();
        logic [63:0] d;
        d = 64'd0;
        for (int j = 0; j < 8; j++) d = (d << 8) | 64'(mh[j]);
        return d ^ mlen;
    endfunction

    // Drive one command at a falling edge; it is sampled on the next rising edge.
    task automatic cmd(input logic [1:0] c, input logic [7:0] b);
        @(negedge clk);
        message_valid = 1'b1;
        state = c;
        message_byte = b;
        @(negedge clk);
        message_valid = 1'b0;
        state = 2'b11;
    endtask

    task automatic head();
        cmd(2'b00, 8'd0);
        if (mode != 0 || mode == 0) begin
            model_init();
            mode = 1;
        end
        check("head_ready_clear", {63'd0, digest_ready}, 64'd0);
        check("head_digest_clear", digest, 64'd0);
    endtask

    task automatic msg(input logic [7:0] b);
        int cnt;
        cmd(2'b10, b);
        if (mode == 1) begin
            model_absorb(b);
            cnt = 0;
            while (next_byte && cnt < 100) begin
                cnt++;
                @(negedge clk);
            end
            check("busy_len", 64'(cnt), 64'd32);
        end else begin
            check("msg_ignored", {63'd0, next_byte}, 64'd0);
        end
    endtask

    task automatic tail();
        if (mode == 1) begin
            last_exp = model_digest();
            exp_q.push_back(last_exp);
            mode = 2;
        end
        cmd(2'b01, 8'd0);
    endtask

    task automatic hash_str(input string s);
        head();
        for (int i = 0; i < s.len(); i++) msg(s[i]);
        tail();
    endtask

    // Monitor: every rising digest_ready presents one digest to compare.
    initial begin
        logic prev;
        logic [63:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (digest_ready && !prev) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL digest_unexpected: got %h, expected none", digest);
                end else begin
                    e = exp_q.pop_front();
                    check("digest", digest, e);
                end
            end
            prev = digest_ready;
        end
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1);
    end

    initial begin
        string big;
        int n;
        build_sbox();
        model_init();
        mode = 0;

        // Reset
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_digest", digest, 64'd0);
        check("rst_ready", {63'd0, digest_ready}, 64'd0);
        check("rst_busy", {63'd0, next_byte}, 64'd0);
        rst_n = 1'b0;

        // Commands before any head are ignored
        tail();
        check("idle_tail_ready", {63'd0, digest_ready}, 64'd0);
        check("idle_tail_digest", digest, 64'd0);
        msg(8'h11);

        // Empty message: digest is the IV itself
        head();
        exp_q.push_back(64'h34550F14DAC02B3E);
        last_exp = 64'h34550F14DAC02B3E;
        mode = 2;
        cmd(2'b01, 8'd0);
        check("empty_ready", {63'd0, digest_ready}, 64'd1);

        // Commands in DONE other than head are ignored
        tail();
        msg(8'h22);
        check("done_hold_ready", {63'd0, digest_ready}, 64'd1);
        check("done_hold_digest", digest, last_exp);

        hash_str("a");

        // Busy rejection: message 0x42, tail and head all land while absorbing 0x41
        head();
        cmd(2'b10, 8'h41);
        model_absorb(8'h41);
        cmd(2'b10, 8'h42);
        cmd(2'b01, 8'h00);
        cmd(2'b00, 8'h00);
        n = 0;
        while (next_byte && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_done", {63'd0, next_byte}, 64'd0);
        check("busy_tail_ignored", {63'd0, digest_ready}, 64'd0);
        tail();

        hash_str("H4rdw4r3_Tr0j4n");
        hash_str("AlessandroAndGiacomo");
        hash_str("3.141592653589793238");
        big = "";
        for (int i = 0; i < 7; i++) big = {big, "The quick brown fox jumps over the lazy dog. "};
        hash_str(big);

        // Random messages with interleaved no-op commands
        for (int k = 0; k < 4; k++) begin
            head();
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) cmd(2'b11, 8'($urandom));
                msg(8'($urandom));
            end
            tail();
        end

        // Asynchronous reset during round 10 of a byte
        head();
        cmd(2'b10, 8'h5A);
        repeat (9) @(negedge clk);
        check("pre_rst_busy", {63'd0, next_byte}, 64'd1);
        #2 rst_n = 1'b1;
        #1;
        check("async_rst_busy", {63'd0, next_byte}, 64'd0);
        check("async_rst_ready", {63'd0, digest_ready}, 64'd0);
        check("async_rst_digest", digest, 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        model_init();
        mode = 0;
        hash_str("abc");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
